// File: rtl/sr_ff_bank_pkg.sv
// Shared constants for the sr_ff_bank flip-flop bank: mode encodings and
// the policies that resolve the SR=11 input combination.
package sr_ff_bank_pkg;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [1:0] POL_HOLD = 2'd0;
  localparam logic [1:0] POL_CLR  = 2'd1;
  localparam logic [1:0] POL_SET  = 2'd2;
  localparam logic [1:0] POL_TGL  = 2'd3;

endpackage

// File: rtl/sr_ff_cell.sv
// Single-channel next-state logic for the configurable flip-flop bank.
// Purely combinational; the owning bank holds the state register.
module sr_ff_cell
  import sr_ff_bank_pkg::*;
(
  input  logic       q,
  input  logic       a,
  input  logic       b,
  input  logic [1:0] mode,
  input  logic [1:0] policy,
  output logic       q_next,
  output logic       invalid
);

  assign invalid = (mode == MODE_SR) && a && b;

  always_comb begin
    q_next = q;
    case (mode)
      MODE_SR: begin
        case ({a, b})
          2'b01: q_next = 1'b0;
          2'b10: q_next = 1'b1;
          2'b11: begin
            case (policy)
              POL_CLR: q_next = 1'b0;
              POL_SET: q_next = 1'b1;
              POL_TGL: q_next = ~q;
              default: q_next = q;
            endcase
          end
          default: q_next = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = a;
      default: q_next = q ^ a;
    endcase
  end

endmodule

// File: rtl/sr_ff_bank.sv
// WIDTH-channel bank of SR/JK/D/T flip-flops with sticky SR-invalid flags.
// Define SR_FF_BANK_ERR_CNT_EN to add the saturating err_cnt event counter.
module sr_ff_bank
  import sr_ff_bank_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VAL      = {WIDTH{1'b0}},
  parameter int               INVALID_POLICY = 0,
  parameter int               CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] err,
  output logic             err_any
`ifdef SR_FF_BANK_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam logic [1:0] POLICY = INVALID_POLICY[1:0];

  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1 || INVALID_POLICY < 0 || INVALID_POLICY > 3)
  begin : g_bad_param
    $error("sr_ff_bank: parameter out of range");
  end

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] err_reg, err_next;
  logic [WIDTH-1:0] cell_next, cell_invalid, invalid_ev;

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_cell
    sr_ff_cell u_cell (
      .q      (q_reg[gi]),
      .a      (a[gi]),
      .b      (b[gi]),
      .mode   (mode),
      .policy (POLICY),
      .q_next (cell_next[gi]),
      .invalid(cell_invalid[gi])
    );
  end

  // An invalid event only counts when the bank is actually clocking.
  assign invalid_ev = cell_invalid & {WIDTH{ce}};
  assign q_next     = ce ? cell_next : q_reg;
  // A fresh event on a channel beats a simultaneous clear.
  assign err_next   = err_clr ? invalid_ev : (err_reg | invalid_ev);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg   <= RESET_VAL;
      err_reg <= '0;
    end else begin
      q_reg   <= q_next;
      err_reg <= err_next;
    end
  end

  assign q       = q_reg;
  assign qn      = ~q_reg;
  assign err     = err_reg;
  assign err_any = |err_reg;

`ifdef SR_FF_BANK_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             any_ev;

  assign any_ev = |invalid_ev;

  always_comb begin
    cnt_next = cnt_reg;
    if (err_clr)
      cnt_next = any_ev ? CNT_ONE : '0;
    else if (any_ev && cnt_reg != CNT_MAX)
      cnt_next = cnt_reg + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_next;
  end

  assign err_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: directed scenarios then random traffic
// compared against a vector-level behavioural model.
module tb_sr_ff_bank;

  localparam int         WIDTH = 8;
  localparam logic [7:0] RV    = 8'hA5;
  localparam int         POL   = 3;
  localparam int         CNT_W = 2;
  localparam int         CMAX  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst, ce, err_clr;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic [7:0] q, qn, err;
  logic       err_any;
`ifdef SR_FF_BANK_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  sr_ff_bank #(
    .WIDTH(WIDTH), .RESET_VAL(RV), .INVALID_POLICY(POL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .a(a), .b(b),
    .err_clr(err_clr), .q(q), .qn(qn), .err(err), .err_any(err_any)
`ifdef SR_FF_BANK_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] m_q   = 8'h00;
  logic [7:0] m_err = 8'h00;
  int         m_cnt = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference: whole-vector rules straight from the behaviour description.
  task automatic model(input logic r, input logic c, input logic [1:0] md,
                       input logic [7:0] av, input logic [7:0] bv, input logic clr);
    logic [7:0] both, ev;
    both = av & bv;
    ev   = (c && md == 2'd0) ? both : 8'h00;
    if (r) begin
      m_q = RV; m_err = 8'h00; m_cnt = 0;
      return;
    end
    if (c) begin
      case (md)
        2'd0: begin
          m_q = (m_q & ~(bv & ~av)) | (av & ~bv);
          case (POL)
            1: m_q = m_q & ~both;
            2: m_q = m_q | both;
            3: m_q = m_q ^ both;
            default: ;
          endcase
        end
        2'd1: m_q = ((m_q & ~(bv & ~av)) | (av & ~bv)) ^ both;
        2'd2: m_q = av;
        default: m_q = m_q ^ av;
      endcase
    end
    m_err = clr ? ev : (m_err | ev);
    if (clr) m_cnt = (ev != 0) ? 1 : 0;
    else if (ev != 0 && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic step(input logic r, input logic c, input logic [1:0] md,
                      input logic [7:0] av, input logic [7:0] bv, input logic clr);
    rst = r; ce = c; mode = md; a = av; b = bv; err_clr = clr;
    model(r, c, md, av, bv, clr);
    @(posedge clk);
    #1;
    chk("q", q, m_q);
    chk("qn", qn, ~m_q);
    chk("err", err, m_err);
    chk("err_any", {7'd0, err_any}, {7'd0, |m_err});
`ifdef SR_FF_BANK_ERR_CNT_EN
    chk("err_cnt", {6'd0, err_cnt}, m_cnt[7:0]);
`endif
    $display("[TB] t=%0t rst=%b ce=%b mode=%0d a=%h b=%h clr=%b -> q=%h err=%h",
             $time, r, c, md, av, bv, clr, q, err);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; mode = 2'd0; a = '0; b = '0; err_clr = 1'b0;
    @(posedge clk); #1;

    // Reset with random data and ce=0.
    step(1'b1, 1'b0, 2'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    chk("rst_q", q, 8'hA5);
    chk("rst_qn", qn, 8'h5A);
    chk("rst_err", err, 8'h00);

    // SR invalid with toggle policy.
    step(1'b0, 1'b1, 2'd2, 8'h0F, 8'h00, 1'b0);
    step(1'b0, 1'b1, 2'd0, 8'h03, 8'h03, 1'b0);
    chk("sr11_q", q, 8'h0C);
    chk("sr11_err", err, 8'h03);
    step(1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
    chk("sr00_q", q, 8'h0C);

    // JK toggling, no error flagged.
    step(1'b0, 1'b1, 2'd0, 8'h00, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0);
    chk("jk_q", q, 8'hFF);
    chk("jk_err", err, 8'h00);

    // D then T on back-to-back edges.
    step(1'b0, 1'b1, 2'd2, 8'h3C, 8'h55, 1'b0);
    chk("d_q", q, 8'h3C);
    step(1'b0, 1'b1, 2'd3, 8'h0F, 8'hAA, 1'b0);
    chk("t_q", q, 8'h33);

    // Clock enable gating and clear interactions.
    step(1'b0, 1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);
    chk("ce0_err", err, 8'h01);
    step(1'b0, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b1);
    chk("ce0_clr", err, 8'h00);
    step(1'b0, 1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
    step(1'b0, 1'b1, 2'd0, 8'h80, 8'h80, 1'b1);
    chk("clr_set_wins", err, 8'h80);

    // Counter saturation and clear-with-event.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0);
`ifdef SR_FF_BANK_ERR_CNT_EN
    chk("cnt_sat", {6'd0, err_cnt}, 8'd3);
`endif
    step(1'b0, 1'b1, 2'd0, 8'h10, 8'h10, 1'b1);
`ifdef SR_FF_BANK_ERR_CNT_EN
    chk("cnt_clr_ev", {6'd0, err_cnt}, 8'd1);
`endif

    // Random traffic, occasional reset.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- WIDTH-channel bank of configurable edge-triggered flip-flops; one global mode selects SR, JK, D or T behaviour for all channels.
- Successor to the single-bit SR flip-flop. The illegal SR=11 case is resolved deterministically by a parameterised policy instead of driving X.
- Each channel keeps a sticky error flag when SR=11 occurs. The bank is the team's generic state-bit primitive for control and status logic.

Parameters:
- WIDTH, 8, number of independent channels (1..64)
- RESET_VAL, {WIDTH{1'b0}}, per-channel q value loaded on reset
- INVALID_POLICY, 0, SR=11 resolution: 0 hold, 1 clear, 2 set, 3 toggle
- CNT_W, 8, width of optional error-event counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; low = hold all state
- mode  in  2  00 SR, 01 JK, 10 D, 11 T
- a  in  WIDTH  per channel S / J / D / T input
- b  in  WIDTH  per channel R / K input; ignored in D and T modes
- err_clr  in  1  clears all sticky error flags
- q  out  WIDTH  registered state
- qn  out  WIDTH  ~q, combinational
- err  out  WIDTH  sticky per-channel SR-invalid flag
- err_any  out  1  OR-reduction of err, combinational

Behaviour:
- Reset: rst high at a rising edge sets q=RESET_VAL, err=0 (and err_cnt=0 if present). rst overrides ce, err_clr and all data. Reset mid-operation simply reloads these values; no pending state survives.
- q updates at the rising edge after inputs are sampled; latency 1 cycle. qn and err_any follow q and err with no extra delay.
- mode is sampled every edge. A mode change takes effect on the same edge, with no pipeline or drain.
- ce=0: q and err hold; inputs are ignored. err_clr is still honoured when ce=0.
- Per channel i, when ce=1:
  - SR: 00 hold; 01 q=0; 10 q=1; 11 apply INVALID_POLICY and set err[i].
  - JK: 00 hold; 01 q=0; 10 q=1; 11 q=~q. No error is flagged in JK mode.
  - D: q=a[i].
  - T: a[i]=1 toggles q; a[i]=0 holds.
- No output ever takes X or Z.
- err[i] sets only on the SR=11, ce=1 condition and stays set until err_clr or rst.
- Simultaneous err_clr and a new invalid event on channel i: err[i]=1 (set wins). Channels without an event are cleared.
- Channels are fully independent; no cross-channel interaction except err_any.

Optional Feature:
- Macro SR_FF_BANK_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt[CNT_W-1:0], counting cycles in which at least one channel has an invalid event (ce=1, mode=SR).
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared by rst or err_clr. When clear and an event coincide, the counter loads 1.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sr_ff_bank_pkg holds:
  - mode encoding constants MODE_SR, MODE_JK, MODE_D, MODE_T;
  - policy constants POL_HOLD, POL_CLR, POL_SET, POL_TGL.
- Sub-module sr_ff_cell: single-channel combinational next-state and invalid-detect logic, with inputs q, a, b, mode and policy.
- The top instantiates the cell WIDTH times with a generate loop and owns all registers and the counter.

Test Plan:
1. Reset with RESET_VAL=8'hA5, inputs random -> q=8'hA5, qn=8'h5A, err=0 the cycle after rst; rst also overrides ce=0.
2. SR mode, INVALID_POLICY=3, q=8'h0F, a=8'h03, b=8'h03 -> q=8'h0C, err=8'h03, err_any=1. Next cycle a=b=0 -> q holds, err holds.
3. JK mode, q=8'h00, a=b=8'hFF for 3 cycles -> q toggles FF,00,FF; err stays 0.
4. D then T mode on consecutive edges, with mode changed between them:
   - D with a=8'h3C -> q=8'h3C;
   - T with a=8'h0F -> q=8'h33.
5. ce=0 with SR=11 on all channels -> q and err unchanged. err_clr with ce=0 -> err=0. err_clr plus a new invalid on bit 7 -> err=8'h80.
6. With SR_FF_BANK_ERR_CNT_EN and CNT_W=2, five invalid cycles -> err_cnt=3 (saturated). err_clr coincident with an event -> err_cnt=1.
